// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and default sizes for the data-RAM arbiter
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int TAM_POSICIONES_DEF = 1024;
    localparam int TAM_PALABRA_DEF    = 32;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick: on a tie the requester that did not win last time wins
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin sequencer driving one single-port RAM access per 3 cycles
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int TAM_POSICIONES = TAM_POSICIONES_DEF,
    parameter  int TAM_PALABRA    = TAM_PALABRA_DEF,
    localparam int AW             = $clog2(TAM_POSICIONES),
    localparam int DW             = TAM_PALABRA
) (
    input  logic          CLK,
    input  logic          RSTa,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          RAM_WR,
    output logic          RAM_OE,
    output logic [AW-1:0] RAM_ADDRESS,
    output logic [DW-1:0] RAM_DATA_IN,
    input  logic [DW-1:0] RAM_DATA_OUT
);

    arb_state_t    state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic pick_valid;
    logic pick_winner;

    rr_pick2 u_pick (
        .req    ({REQ1, REQ0}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    sel_d   = pick_winner;
                    last_d  = pick_winner;
                    we_d    = pick_winner ? WE1    : WE0;
                    addr_d  = pick_winner ? ADDR1  : ADDR0;
                    wdata_d = pick_winner ? WDATA1 : WDATA0;
                end
            end
            ACCESS: begin
                // RAM read path is combinational, so data is valid on the closing edge
                if (!we_q) begin
                    rdata_d = RAM_DATA_OUT;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        RAM_WR      = (state_q == ACCESS) &  we_q;
        RAM_OE      = (state_q == ACCESS) & ~we_q;
        ACK0        = (state_q == DONE)   & ~sel_q;
        ACK1        = (state_q == DONE)   &  sel_q;
        BUSY        = (state_q != IDLE);
        RAM_ADDRESS = addr_q;
        RAM_DATA_IN = wdata_q;
        RDATA       = rdata_q;
    end

endmodule
